// File: rtl/joe_anim_ctrl.sv
// Joe sprite animation/motion controller: per-frame pose FSM (run, attack, cast, knock-back)
// with saturating centre-x tracking. All state advances only on frame_tick.
module joe_anim_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 6,
  parameter int unsigned STEP_PX         = 2,
  parameter int unsigned FLY_PX          = 3,
  parameter int unsigned ATTACK_FRAMES   = 12,
  parameter int unsigned CAST_FRAMES     = 16,
  parameter int unsigned HIT_FRAMES      = 30,
  parameter int unsigned X_MIN           = 45,
  parameter int unsigned X_MAX           = 594,
  parameter int unsigned X_START         = 320,
  parameter int unsigned Y_GROUND        = 400
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       attack,
  input  logic       cast,
  input  logic [1:0] hit_in,
  output logic       show_joe,
  output logic [9:0] centerx,
  output logic [9:0] centery,
  output logic [1:0] joe_run_left,
  output logic [1:0] joe_run_right,
  output logic       stand,
  output logic       right_hand_warm,
  output logic       left_hand_go,
  output logic [1:0] hit_joe
);
  localparam int unsigned AC_MAX  = (ATTACK_FRAMES > CAST_FRAMES) ? ATTACK_FRAMES : CAST_FRAMES;
  localparam int unsigned DUR_MAX = (AC_MAX > HIT_FRAMES) ? AC_MAX : HIT_FRAMES;
  localparam int CW = ($clog2(DUR_MAX) < 5) ? 5 : $clog2(DUR_MAX);
  localparam int SW = $clog2(FRAMES_PER_STEP) + 1;

  typedef enum logic [2:0] {IDLE, RUN_L, RUN_R, ATTACK, CAST, HIT} state_t;

  state_t          state, nxt;
  logic [CW-1:0]   tick_cnt;
  logic [SW-1:0]   step_cnt, step_nxt;
  logic            run_frm, frm_nxt;   // 0 selects run frame 1, 1 selects frame 2
  logic [1:0]      hit_pend, hit_dir, hit_eff, dir_next;
  logic            atk_prev, cast_prev;
  logic            free, hit_now, atk_edge, cast_edge, pose_done, minus;
  logic [10:0]     dx, x_sum;
  logic [9:0]      x_new;
  logic [1:0]      frame_sel;

  assign free      = (state == IDLE) || (state == RUN_L) || (state == RUN_R);
  // Hits landing during knock-back are dropped, both pending and same-cycle ones.
  assign hit_now   = ((hit_in == 2'b01) || (hit_in == 2'b10)) && (state != HIT);
  assign hit_eff   = hit_now ? hit_in : hit_pend;
  assign dir_next  = (hit_eff != 2'b00) ? hit_eff : hit_dir;
  assign atk_edge  = attack & ~atk_prev;
  assign cast_edge = cast & ~cast_prev;
  assign frame_sel = frm_nxt ? 2'd2 : 2'd1;

  always_comb begin
    pose_done = 1'b0;
    case (state)
      ATTACK:  pose_done = (tick_cnt == CW'(ATTACK_FRAMES - 1));
      CAST:    pose_done = (tick_cnt == CW'(CAST_FRAMES - 1));
      HIT:     pose_done = (tick_cnt == CW'(HIT_FRAMES - 1));
      default: pose_done = 1'b0;
    endcase
    nxt = state;
    if (hit_eff != 2'b00)                nxt = HIT;
    else if (free && atk_edge)           nxt = ATTACK;
    else if (free && cast_edge)          nxt = CAST;
    else if (!free)                      nxt = pose_done ? IDLE : state;
    else if (move_left ^ move_right)     nxt = move_left ? RUN_L : RUN_R;
    else                                 nxt = IDLE;
  end

  always_comb begin
    if (nxt != state) begin
      step_nxt = '0;
      frm_nxt  = 1'b0;
    end else if (step_cnt == SW'(FRAMES_PER_STEP - 1)) begin
      step_nxt = '0;
      frm_nxt  = ~run_frm;
    end else begin
      step_nxt = step_cnt + SW'(1);
      frm_nxt  = run_frm;
    end
  end

  // Position moves in 11 bits and saturates to [X_MIN, X_MAX]; it never wraps.
  always_comb begin
    dx    = '0;
    minus = 1'b0;
    case (nxt)
      RUN_R:   dx = 11'(STEP_PX);
      RUN_L:   begin dx = 11'(STEP_PX); minus = 1'b1; end
      HIT:     begin dx = 11'(FLY_PX);  minus = (dir_next == 2'b10); end
      default: dx = '0;
    endcase
    x_sum = minus ? ({1'b0, centerx} - dx) : ({1'b0, centerx} + dx);
    if (minus && ({1'b0, centerx} < (11'(X_MIN) + dx))) x_new = 10'(X_MIN);
    else if (!minus && (x_sum > 11'(X_MAX)))            x_new = 10'(X_MAX);
    else                                                x_new = x_sum[9:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      step_cnt        <= '0;
      run_frm         <= 1'b0;
      hit_pend        <= 2'b00;
      hit_dir         <= 2'b00;
      atk_prev        <= 1'b0;
      cast_prev       <= 1'b0;
      show_joe        <= 1'b1;
      centerx         <= 10'(X_START);
      centery         <= 10'(Y_GROUND);
      joe_run_left    <= 2'd0;
      joe_run_right   <= 2'd0;
      stand           <= 1'b1;
      right_hand_warm <= 1'b0;
      left_hand_go    <= 1'b0;
      hit_joe         <= 2'b00;
    end else begin
      if (frame_tick)   hit_pend <= 2'b00;
      else if (hit_now) hit_pend <= hit_in;
      if (frame_tick) begin
        atk_prev        <= attack;
        cast_prev       <= cast;
        state           <= nxt;
        tick_cnt        <= (nxt != state) ? '0 : tick_cnt + CW'(1);
        step_cnt        <= step_nxt;
        run_frm         <= frm_nxt;
        hit_dir         <= dir_next;
        centerx         <= x_new;
        stand           <= (nxt == IDLE) || (nxt == ATTACK) || (nxt == CAST);
        right_hand_warm <= (nxt == ATTACK);
        left_hand_go    <= (nxt == CAST);
        hit_joe         <= (nxt == HIT) ? dir_next : 2'b00;
        joe_run_left    <= (nxt == RUN_L) ? frame_sel : 2'd0;
        joe_run_right   <= (nxt == RUN_R) ? frame_sel : 2'd0;
      end
    end
  end
endmodule

// File: tb/tb_joe_anim_ctrl.sv
// Scoreboard bench for joe_anim_ctrl: a tick-level behavioural model predicts outputs per frame,
// a monitor compares after every tick and checks outputs hold between ticks.
module tb_joe_anim_ctrl;
  localparam int F = 6, STEP = 2, FLY = 3, ATKN = 12, CSTN = 16, HITN = 30;
  localparam int XMIN = 45, XMAX = 594, XST = 320, YG = 400, GAP = 2;
  localparam int M_IDLE = 0, M_RL = 1, M_RR = 2, M_ATK = 3, M_CST = 4, M_HIT = 5;

  logic       Clk = 0, Reset = 0, frame_tick = 0;
  logic       move_left = 0, move_right = 0, attack = 0, cast = 0;
  logic [1:0] hit_in = 2'b00;
  logic       show_joe, stand, right_hand_warm, left_hand_go;
  logic [9:0] centerx, centery;
  logic [1:0] joe_run_left, joe_run_right, hit_joe;

  joe_anim_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .move_left(move_left),
    .move_right(move_right), .attack(attack), .cast(cast), .hit_in(hit_in),
    .show_joe(show_joe), .centerx(centerx), .centery(centery),
    .joe_run_left(joe_run_left), .joe_run_right(joe_run_right), .stand(stand),
    .right_hand_warm(right_hand_warm), .left_hand_go(left_hand_go), .hit_joe(hit_joe)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       show;
    logic [9:0] cx, cy;
    logic [1:0] rl, rr;
    logic       stand, rhw, lhg;
    logic [1:0] hit;
  } obs_t;

  obs_t sb[$];
  obs_t last_exp;
  int   checks = 0, errors = 0;
  logic tick_d = 1'b0;

  // behavioural model state
  int m_mode, m_ticks, m_x, m_dir, m_pend;
  bit m_pa, m_pc;

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.show = 1'b1; o.cx = 10'(XST); o.cy = 10'(YG); o.stand = 1'b1;
    return o;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ticks = 1; m_x = XST; m_dir = 0; m_pend = 0; m_pa = 0; m_pc = 0;
  endtask

  function automatic int dur(input int mode);
    return (mode == M_ATK) ? ATKN : (mode == M_CST) ? CSTN : HITN;
  endfunction

  task automatic model_hit_idle(input int h);
    if ((h == 1 || h == 2) && m_mode != M_HIT) m_pend = h;
  endtask

  function automatic obs_t model_tick(input bit ml, input bit mr, input bit a, input bit c, input int h);
    obs_t o;
    int eff, nm, frame;
    bit ae, ce, free;
    eff = ((h == 1 || h == 2) && m_mode != M_HIT) ? h : m_pend;
    ae = a && !m_pa; ce = c && !m_pc;
    m_pa = a; m_pc = c; m_pend = 0;
    free = (m_mode <= M_RR);
    nm = m_mode;
    if (eff != 0) begin nm = M_HIT; m_dir = eff; end
    else if (free && ae) nm = M_ATK;
    else if (free && ce) nm = M_CST;
    else if (!free) begin if (m_ticks == dur(m_mode)) nm = M_IDLE; end
    else if (ml != mr) nm = ml ? M_RL : M_RR;
    else nm = M_IDLE;
    m_ticks = (nm == m_mode) ? m_ticks + 1 : 1;
    m_mode = nm;
    if (m_mode == M_RR) m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP;
    if (m_mode == M_RL) m_x = (m_x - STEP < XMIN) ? XMIN : m_x - STEP;
    if (m_mode == M_HIT) begin
      if (m_dir == 1) m_x = (m_x + FLY > XMAX) ? XMAX : m_x + FLY;
      else            m_x = (m_x - FLY < XMIN) ? XMIN : m_x - FLY;
    end
    frame = (((m_ticks - 1) / F) % 2 == 0) ? 1 : 2;
    o = '0;
    o.show  = 1'b1;
    o.cx    = 10'(m_x);
    o.cy    = 10'(YG);
    o.rl    = (m_mode == M_RL) ? 2'(frame) : 2'd0;
    o.rr    = (m_mode == M_RR) ? 2'(frame) : 2'd0;
    o.stand = (m_mode == M_IDLE || m_mode == M_ATK || m_mode == M_CST);
    o.rhw   = (m_mode == M_ATK);
    o.lhg   = (m_mode == M_CST);
    o.hit   = (m_mode == M_HIT) ? 2'(m_dir) : 2'b00;
    return o;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // one frame: GAP quiet cycles then the tick cycle; hit pulse lands on cycle hpos (GAP = tick cycle)
  task automatic do_frame(input bit ml, input bit mr, input bit a, input bit c,
                          input logic [1:0] h, input int hpos);
    move_left = ml; move_right = mr; attack = a; cast = c;
    for (int i = 0; i <= GAP; i++) begin
      @(negedge Clk);
      frame_tick = (i == GAP);
      hit_in = (i == hpos) ? h : 2'b00;
      if (i == GAP) sb.push_back(model_tick(ml, mr, a, c, int'(hit_in)));
      else          model_hit_idle(int'(hit_in));
    end
    @(negedge Clk);
    frame_tick = 1'b0; hit_in = 2'b00;
  endtask

  always @(posedge Clk) tick_d <= frame_tick;

  always @(negedge Clk) begin
    obs_t got, exp;
    got = {show_joe, centerx, centery, joe_run_left, joe_run_right, stand,
           right_hand_warm, left_hand_go, hit_joe};
    checks++;
    if (tick_d) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got=%h exp=<none>", got);
      end else begin
        exp = sb.pop_front();
        last_exp = exp;
        if (got !== exp) begin
          errors++;
          $display("FAIL tick_out got=%h exp=%h", got, exp);
        end
      end
    end else if (got !== last_exp) begin
      errors++;
      $display("FAIL hold_out got=%h exp=%h", got, last_exp);
    end
  end

  initial begin
    int cnt, x0;
    last_exp = reset_obs();
    model_reset();
    #1 Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rst_cx", int'(centerx), XST);
    chk("rst_cy", int'(centery), YG);
    chk("rst_stand", int'(stand), 1);
    chk("rst_show", int'(show_joe), 1);
    Reset = 1'b0;

    // run right 13 ticks
    for (int k = 1; k <= 13; k++) begin
      do_frame(0, 1, 0, 0, 2'b00, 0);
      chk("run_r_frame", int'(joe_run_right), (k <= 6 || k == 13) ? 1 : 2);
    end
    chk("run_r_cx", int'(centerx), 346);
    repeat (27) do_frame(0, 1, 0, 0, 2'b00, 0);
    chk("run_r_cx400", int'(centerx), 400);

    // asynchronous reset mid-run
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_cx", int'(centerx), XST);
    chk("async_rst_stand", int'(stand), 1);
    chk("async_rst_rr", int'(joe_run_right), 0);
    model_reset();
    last_exp = reset_obs();
    @(negedge Clk);
    Reset = 1'b0;

    // left limit
    repeat (140) do_frame(1, 0, 0, 0, 2'b00, 0);
    chk("left_clamp", int'(centerx), XMIN);
    do_frame(0, 1, 0, 0, 2'b00, 0);
    chk("right_from45", int'(centerx), 47);
    for (int k = 1; k <= 8; k++) begin
      do_frame(1, 0, 0, 0, 2'b00, 0);
      if (k == 7) chk("left_toggle_at_limit", int'(joe_run_left), 2);
    end
    chk("left_hold", int'(centerx), XMIN);

    // attack held 40 ticks
    do_frame(0, 0, 0, 0, 2'b00, 0);
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      do_frame(0, 0, 1, 0, 2'b00, 0);
      if (right_hand_warm) cnt++;
      if (k == 13) chk("atk_end_stand", int'(stand), 1);
    end
    chk("atk_len", cnt, ATKN);
    do_frame(0, 0, 0, 0, 2'b00, 0);
    do_frame(0, 0, 1, 0, 2'b00, 0);
    chk("atk_repress", int'(right_hand_warm), 1);
    repeat (15) do_frame(0, 0, 0, 0, 2'b00, 0);

    // hit pre-empts attack, second hit ignored
    x0 = int'(centerx);
    for (int k = 1; k <= 5; k++) do_frame(0, 0, 1, 0, 2'b00, 0);
    do_frame(0, 0, 1, 0, 2'b01, 0);
    chk("hit_dir", int'(hit_joe), 1);
    chk("hit_rhw", int'(right_hand_warm), 0);
    chk("hit_cx1", int'(centerx), x0 + FLY);
    for (int k = 7; k <= 35; k++) do_frame(0, 0, 1, 0, (k == 10) ? 2'b10 : 2'b00, 1);
    chk("hit_last", int'(hit_joe), 1);
    chk("hit_cx30", int'(centerx), x0 + 30 * FLY);
    do_frame(0, 0, 1, 0, 2'b00, 0);
    chk("hit_end", int'(hit_joe), 0);
    chk("hit_end_stand", int'(stand), 1);

    // both moves held, hit 11 ignored
    x0 = int'(centerx);
    for (int k = 1; k <= 5; k++) do_frame(1, 1, 0, 0, (k == 3) ? 2'b11 : 2'b00, GAP);
    chk("both_cx", int'(centerx), x0);
    chk("both_stand", int'(stand), 1);
    chk("both_hit", int'(hit_joe), 0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      bit ml, mr, a, c;
      logic [1:0] h;
      ml = ($urandom_range(0, 2) != 0);
      mr = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 5) == 0);
      c  = ($urandom_range(0, 5) == 0);
      h  = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      do_frame(ml, mr, a, c, h, $urandom_range(0, GAP));
    end

    repeat (3) @(negedge Clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/joe_anim_ctrl.md
# joe_anim_ctrl

Frame-rate animation and motion controller for the Joe sprite. It turns player commands and hit events into the pose selects consumed by `joe_address` (run frames, hand poses, stand) and `joe_fly_address` (hit direction), and it tracks the sprite centre position. It sits between the keyboard/game-logic layer and the sprite address generators, and advances once per video frame.

## Interface
- `FRAMES_PER_STEP`, 6, frame ticks per run-frame toggle (≥1)
- `STEP_PX`, 2, horizontal pixels per tick while running
- `FLY_PX`, 3, horizontal pixels per tick while knocked back
- `ATTACK_FRAMES`, 12, ticks the right-hand attack pose is held
- `CAST_FRAMES`, 16, ticks the left-hand cast pose is held
- `HIT_FRAMES`, 30, ticks the knock-back (fly) pose is held
- `X_MIN`, 45 / `X_MAX`, 594 / `X_START`, 320 / `Y_GROUND`, 400: position limits and reset values (10-bit)

- `Clk` in 1: system clock
- `Reset` in 1: asynchronous, active-high reset
- `frame_tick` in 1: one-`Clk` pulse per frame (vsync); all state advances only on this
- `move_left`, `move_right` in 1: level commands
- `attack` in 1: level; rising edge between ticks starts the attack
- `cast` in 1: level; rising edge between ticks starts the cast
- `hit_in` in 2: one-`Clk` pulse; 01 = hit from left (fly right), 10 = hit from right (fly left), 00/11 = none
- `show_joe` out 1: sprite enable
- `centerx`, `centery` out 10: sprite centre
- `joe_run_left`, `joe_run_right` out 2: run frame select, 0 = not running, 1/2 = frames
- `stand` out 1: standing pose
- `right_hand_warm` out 1: attack pose
- `left_hand_go` out 1: cast pose
- `hit_joe` out 2: knock-back direction, 00 = none

## Operation
- States: IDLE, RUN_L, RUN_R, ATTACK, CAST, HIT. Internal `tick_cnt` (≥5 bits) counts ticks in current state; cleared on every state change.
- `hit_in` ≠ 00/11 sets a pending-hit register (direction kept, later pulse overwrites); consumed at next `frame_tick`. Hits arriving while in HIT are dropped.
- `attack`/`cast` sampled at each `frame_tick`; edge = sampled 1 with previous sample 0. Holding the key does not retrigger.
- Transition priority at each tick: pending hit → HIT; else attack edge (from IDLE/RUN_*) → ATTACK; else cast edge (from IDLE/RUN_*) → CAST; else ATTACK/CAST/HIT continue until `tick_cnt` = duration−1, then IDLE; else from IDLE/RUN_*: exactly one of `move_left`/`move_right` → RUN_L/RUN_R, both or neither → IDLE.
- HIT pre-empts ATTACK and CAST mid-pose. ATTACK/CAST ignore move commands and further edges.
- Outputs by state:
  - IDLE: `stand`=1, rest 0.
  - RUN_R: `joe_run_right` ∈{1,2}, `stand`=0; centerx += STEP_PX per tick. RUN_L mirror with `joe_run_left`, centerx −= STEP_PX.
  - Run frame: 1 on entry; toggles 1↔2 every FRAMES_PER_STEP ticks in state; RUN_L↔RUN_R direct switch restarts at 1.
  - ATTACK: `stand`=1, `right_hand_warm`=1. CAST: `stand`=1, `left_hand_go`=1.
  - HIT: `hit_joe` = latched direction, `stand`=0, run selects 0; centerx ±FLY_PX per tick (01 → +, 10 → −).
- Position arithmetic in 11 bits, then saturate to [X_MIN, X_MAX]; never wraps. At a limit, run state and frame toggling continue, position holds.
- `centery` constant `Y_GROUND`; `show_joe` constant 1 after reset.

## Timing
- All outputs registered. Reset (asynchronous, any time, including mid-pose): state IDLE, `centerx`=X_START, `centery`=Y_GROUND, `show_joe`=1, `stand`=1, all other outputs 0, pending hit and edge history cleared.
- Latency: inputs sampled on the `Clk` edge where `frame_tick`=1; outputs reflect the new state on that same edge (visible next cycle). No change on cycles without `frame_tick`.
- A `hit_in` pulse on the same cycle as `frame_tick` is consumed on that tick.
- Pose duration N means exactly N ticks with the pose asserted; IDLE outputs on tick N+1.

## Test plan
- Reset mid-RUN_R at centerx=400 → same cycle async: centerx=320, stand=1, joe_run_right=0.
- Hold move_right 13 ticks from IDLE, FRAMES_PER_STEP=6 → joe_run_right 1 for ticks 1–6, 2 for 7–12, 1 at 13; centerx=320+26=346.
- Run left from centerx=47 → 45 after 1 tick, holds 45 thereafter, joe_run_left keeps toggling.
- Attack held 40 ticks → right_hand_warm=1 for exactly 12 ticks, stand=1, then IDLE; no retrigger until attack released and re-pressed.
- hit_in=01 pulse during ATTACK tick 5 → next tick hit_joe=01, right_hand_warm=0, centerx +3/tick for 30 ticks, then IDLE; second hit during HIT ignored.
- move_left and move_right both held → stays IDLE, centerx unchanged; hit_in=11 → no effect.
